// File: rtl/distance_filter.sv
// Ultrasonic distance conditioning: zero-timeout substitution, power-of-two moving
// average, and a hysteretic confirm-counted intrusion state machine.
module distance_filter #(
  parameter int DEPTH_LOG2 = 2,
  parameter int NEAR_CM    = 30,
  parameter int CLEAR_CM   = 40,
  parameter int CONFIRM    = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Sample_Valid,
  input  logic [7:0] Distance_Raw,
  input  logic       Arm,
  output logic [7:0] Distance_Filt,
  output logic       Filt_Valid,
  output logic       Intrusion,
  output logic [1:0] State
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int SUM_W  = 8 + DEPTH_LOG2;
  localparam int FILL_W = DEPTH_LOG2 + 1;
  localparam logic [3:0] CONF = 4'(CONFIRM);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    WATCH    = 2'd1,
    PENDING  = 2'd2,
    ALERT    = 2'd3
  } state_t;

  function automatic logic [7:0] subst_zero(input logic [7:0] d);
    return (d == 8'd0) ? 8'd255 : d;
  endfunction

  function automatic logic [7:0] avg_trunc(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:DEPTH_LOG2];
  endfunction

  logic [7:0]            samp_p0;
  logic                  vld_p0;
  logic [7:0]            win [DEPTH];
  logic [DEPTH_LOG2-1:0] ptr;
  logic [FILL_W-1:0]     fill;
  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      sum_next;
  logic                  full_next;
  state_t                state, state_nx;
  logic [3:0]            cnt, cnt_nx;
  logic                  near, clear;

  // Stage p0: capture the strobed sample with timeouts already substituted
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_p0  <= 1'b0;
      samp_p0 <= '0;
    end else begin
      vld_p0  <= Sample_Valid;
      samp_p0 <= subst_zero(Distance_Raw);
    end
  end

  // Stage p1: window update and averaged output
  assign sum_next  = sum + SUM_W'(samp_p0) - SUM_W'(win[ptr]);
  assign full_next = (fill >= FILL_W'(DEPTH - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
      ptr           <= '0;
      fill          <= '0;
      sum           <= '0;
      Distance_Filt <= '0;
      Filt_Valid    <= 1'b0;
    end else begin
      Filt_Valid <= 1'b0;
      if (vld_p0) begin
        win[ptr] <= samp_p0;
        ptr      <= ptr + DEPTH_LOG2'(1);
        sum      <= sum_next;
        if (fill != FILL_W'(DEPTH)) fill <= fill + FILL_W'(1);
        if (full_next) begin
          Distance_Filt <= avg_trunc(sum_next);
          Filt_Valid    <= 1'b1;
        end
      end
    end
  end

  // Stage p2: intrusion decision on each filtered output
  assign near  = (Distance_Filt <  8'(NEAR_CM));
  assign clear = (Distance_Filt >= 8'(CLEAR_CM));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (!Arm) begin
      state_nx = DISARMED;
      cnt_nx   = 4'd0;
    end else begin
      case (state)
        DISARMED: begin
          state_nx = WATCH;
          cnt_nx   = 4'd0;
        end
        WATCH: begin
          if (Filt_Valid && near) begin
            if (CONF == 4'd1) begin
              state_nx = ALERT;
              cnt_nx   = 4'd0;
            end else begin
              state_nx = PENDING;
              cnt_nx   = 4'd1;
            end
          end
        end
        PENDING: begin
          if (Filt_Valid) begin
            if (!near) begin
              state_nx = WATCH;
              cnt_nx   = 4'd0;
            end else if (cnt + 4'd1 >= CONF) begin
              state_nx = ALERT;
              cnt_nx   = 4'd0;
            end else begin
              cnt_nx = cnt + 4'd1;
            end
          end
        end
        ALERT: begin
          // Anything short of clear lands in the hysteresis band and restarts the count
          if (Filt_Valid) begin
            if (!clear) begin
              cnt_nx = 4'd0;
            end else if (cnt + 4'd1 >= CONF) begin
              state_nx = WATCH;
              cnt_nx   = 4'd0;
            end else begin
              cnt_nx = cnt + 4'd1;
            end
          end
        end
        default: begin
          state_nx = DISARMED;
          cnt_nx   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= DISARMED;
      cnt       <= 4'd0;
      Intrusion <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      Intrusion <= (state_nx == ALERT);
    end
  end

  assign State = state;

endmodule

// File: tb/tb_distance_filter.sv
// Bench for distance_filter: fixed test-plan vectors, corner sequences, and
// randomized traffic compared against a queue-based behavioural model.
module tb_distance_filter;

  localparam int NEAR    = 30;
  localparam int CLEAR   = 40;
  localparam int CONFIRM = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Sample_Valid;
  logic [7:0] Distance_Raw;
  logic       Arm;
  logic [7:0] Distance_Filt;
  logic       Filt_Valid;
  logic       Intrusion;
  logic [1:0] State;

  always #5 CLK = ~CLK;

  distance_filter #(
    .DEPTH_LOG2(2),
    .NEAR_CM(NEAR),
    .CLEAR_CM(CLEAR),
    .CONFIRM(CONFIRM)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .Sample_Valid(Sample_Valid),
    .Distance_Raw(Distance_Raw),
    .Arm(Arm),
    .Distance_Filt(Distance_Filt),
    .Filt_Valid(Filt_Valid),
    .Intrusion(Intrusion),
    .State(State)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: the last four accepted samples kept in a queue
  int hist[$];
  int naccept;
  int pend_v, pend_d;
  int m_filt, m_fv, m_state, m_cnt, m_intr;

  function automatic void model_reset();
    hist.delete();
    naccept = 0;
    pend_v = 0; pend_d = 0;
    m_filt = 0; m_fv = 0; m_state = 0; m_cnt = 0; m_intr = 0;
  endfunction

  function automatic void model_edge(int sv, int raw, int arm);
    int ns, nc, s;
    ns = m_state;
    nc = m_cnt;
    if (arm == 0) begin
      ns = 0; nc = 0;
    end else if (m_state == 0) begin
      ns = 1; nc = 0;
    end else if (m_fv != 0) begin
      if (m_state == 1) begin
        if (m_filt < NEAR) begin
          if (CONFIRM == 1) begin ns = 3; nc = 0; end
          else begin ns = 2; nc = 1; end
        end
      end else if (m_state == 2) begin
        if (m_filt < NEAR) begin
          nc = m_cnt + 1;
          if (nc >= CONFIRM) begin ns = 3; nc = 0; end
        end else begin
          ns = 1; nc = 0;
        end
      end else begin
        if (m_filt >= CLEAR) begin
          nc = m_cnt + 1;
          if (nc >= CONFIRM) begin ns = 1; nc = 0; end
        end else begin
          nc = 0;
        end
      end
    end
    m_state = ns;
    m_cnt   = nc;
    m_intr  = (ns == 3) ? 1 : 0;
    m_fv    = 0;
    if (pend_v != 0) begin
      hist.push_back(pend_d);
      naccept++;
      if (hist.size() > 4) void'(hist.pop_front());
      if (naccept >= 4) begin
        s = 0;
        foreach (hist[i]) s += hist[i];
        m_filt = s / 4;
        m_fv   = 1;
      end
    end
    pend_v = sv;
    pend_d = (raw == 0) ? 255 : raw;
  endfunction

  task automatic check(string tag, int ef, int efv, int est, int ei);
    n_vec++;
    if (Distance_Filt !== 8'(ef) || Filt_Valid !== (efv != 0) ||
        State !== 2'(est) || Intrusion !== (ei != 0)) begin
      n_bad++;
      $display("FAIL %s: got filt=%0d fv=%0b st=%0d intr=%0b, want filt=%0d fv=%0d st=%0d intr=%0d",
               tag, Distance_Filt, Filt_Valid, State, Intrusion, ef, efv, est, ei);
    end
  endtask

  task automatic mcheck(string tag);
    check(tag, m_filt, m_fv, m_state, m_intr);
  endtask

  task automatic expect_bit(string tag, logic got, logic want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0b, want %0b", tag, got, want);
    end
  endtask

  task automatic cyc(int sv, int raw, int arm);
    Sample_Valid = (sv != 0);
    Distance_Raw = 8'(raw);
    Arm          = (arm != 0);
    @(posedge CLK);
    model_edge(sv, raw, arm);
    #1;
  endtask

  typedef struct {
    int sv, raw, arm;
    int ef, efv, est, ei;
  } vec_t;

  vec_t tbl[29] = '{
    '{1, 100, 0,   0, 0, 0, 0},
    '{1, 100, 0,   0, 0, 0, 0},
    '{1, 100, 0,   0, 0, 0, 0},
    '{1, 100, 0,   0, 0, 0, 0},
    '{1,  10, 0, 100, 1, 0, 0},
    '{1,  11, 0,  77, 1, 0, 0},
    '{1,  11, 0,  55, 1, 0, 0},
    '{1,  11, 0,  33, 1, 0, 0},
    '{1,   0, 0,  10, 1, 0, 0},
    '{1,   0, 0,  72, 1, 0, 0},
    '{1,   0, 0, 133, 1, 0, 0},
    '{1,   0, 0, 194, 1, 0, 0},
    '{0,   0, 1, 255, 1, 1, 0},
    '{1,  20, 1, 255, 0, 1, 0},
    '{1,  20, 1, 196, 1, 1, 0},
    '{1,  20, 1, 137, 1, 1, 0},
    '{1,  20, 1,  78, 1, 1, 0},
    '{1,  20, 1,  20, 1, 1, 0},
    '{1,  20, 1,  20, 1, 2, 0},
    '{0,   0, 1,  20, 1, 2, 0},
    '{0,   0, 1,  20, 0, 3, 1},
    '{1,  45, 1,  20, 0, 3, 1},
    '{1,  45, 1,  26, 1, 3, 1},
    '{1,  45, 1,  32, 1, 3, 1},
    '{1,  45, 1,  38, 1, 3, 1},
    '{1,  45, 1,  45, 1, 3, 1},
    '{1,  45, 1,  45, 1, 3, 1},
    '{0,   0, 1,  45, 1, 3, 1},
    '{0,   0, 1,  45, 0, 1, 0}
  };

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int dropped, reached, base, raw, sv, arm;
    RST = 1'b0;
    Sample_Valid = 1'b0;
    Distance_Raw = 8'd0;
    Arm = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", 0, 0, 0, 0);
    @(negedge CLK);
    RST = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].sv, tbl[i].raw, tbl[i].arm);
      check($sformatf("plan_row%0d", i), tbl[i].ef, tbl[i].efv, tbl[i].est, tbl[i].ei);
    end

    // Back into ALERT, then a 35 cm stream sits in the hysteresis band
    repeat (6) begin cyc(1, 20, 1); mcheck("realert"); end
    repeat (2) begin cyc(0, 0, 1); mcheck("realert_idle"); end
    expect_bit("realert_intr", Intrusion, 1'b1);
    repeat (12) begin
      cyc(1, 35, 1);
      mcheck("band35");
      expect_bit("band35_intr", Intrusion, 1'b1);
    end

    // Clear out to WATCH, then drop Arm exactly as PENDING would confirm
    repeat (8) begin cyc(1, 45, 1); mcheck("clear45"); end
    repeat (2) begin cyc(0, 0, 1); mcheck("clear45_idle"); end
    dropped = 0;
    for (int i = 0; i < 20 && dropped == 0; i++) begin
      if (m_state == 2 && m_cnt == 2 && m_fv != 0 && m_filt < NEAR) begin
        cyc(1, 20, 0);
        mcheck("arm_drop");
        expect_bit("arm_drop_state0", (State == 2'd0), 1'b1);
        dropped = 1;
      end else begin
        cyc(1, 20, 1);
        mcheck("pending_walk");
      end
    end
    n_vec++;
    if (dropped == 0) begin
      n_bad++;
      $display("FAIL arm_drop_reach: got no PENDING count=2 within 20 cycles, want one");
    end
    repeat (4) begin
      cyc(1, 20, 0);
      mcheck("disarmed_near");
      expect_bit("disarmed_intr", Intrusion, 1'b0);
    end

    // Asynchronous reset while in ALERT
    reached = 0;
    for (int i = 0; i < 16 && reached == 0; i++) begin
      cyc(1, 20, 1);
      mcheck("to_alert");
      if (m_state == 3) reached = 1;
    end
    expect_bit("to_alert_reached", State == 2'd3, 1'b1);
    #2;
    RST = 1'b0;
    Sample_Valid = 1'b0;
    #1;
    model_reset();
    check("async_reset", 0, 0, 0, 0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) begin cyc(1, 20, 1); mcheck("post_reset_fill"); end
    repeat (3) begin
      cyc(0, 0, 1);
      mcheck("post_reset_idle");
      expect_bit("post_reset_nofv", Filt_Valid, 1'b0);
    end

    // Randomized traffic with slowly drifting distance levels
    base = 20;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 3))
          0: base = $urandom_range(5, 25);
          1: base = $urandom_range(28, 42);
          2: base = $urandom_range(45, 200);
          default: base = 0;
        endcase
      end
      raw = (base == 0) ? 0 : base + $urandom_range(0, 4);
      if (raw > 255) raw = 255;
      sv  = ($urandom_range(0, 9) < 7) ? 1 : 0;
      arm = ($urandom_range(0, 79) == 0) ? 0 : 1;
      cyc(sv, raw, arm);
      mcheck("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/distance_filter.md
# distance_filter

Conditioning and intrusion-decision stage between the ultrasonic sensor controller and the alarm controller. It takes the raw 8-bit distance sample and its strobe, and removes timeout zeros. It smooths the samples with a power-of-two moving average. A hysteretic, confirm-counted state machine then produces the armed-intrusion flag that drives the alarm controller. It runs on the divided trigger clock shared by the sensor and alarm stages.

## Interface
- DEPTH_LOG2, 2: log2 of the averaging window; window = 4 samples.
- NEAR_CM, 30: filtered distance strictly below this value counts as "near".
- CLEAR_CM, 40: filtered distance at or above this value counts as "clear"; must be ≥ NEAR_CM.
- CONFIRM, 3: consecutive qualifying filtered outputs needed to change alarm state; range 1–15.

- CLK  in  1  clock; one clock only, the divided trigger clock.
- RST  in  1  reset; asynchronous, active-low.
- Sample_Valid  in  1  one-cycle strobe when Distance_Raw holds a new measurement; back-to-back strobes are legal.
- Distance_Raw  in  8  raw distance in cm; 0 means no echo/timeout.
- Arm  in  1  level; 1 = system armed.
- Distance_Filt  out  8  moving-average distance in cm.
- Filt_Valid  out  1  one-cycle strobe; Distance_Filt was updated this cycle.
- Intrusion  out  1  level; 1 while in ALERT.
- State  out  2  current FSM state code, for debug and display.

## Operation
- Zero substitution: a Distance_Raw of 0 is written into the window as 255. All other values are stored unchanged.
- Window: circular buffer of 2^DEPTH_LOG2 × 8-bit entries with a write pointer that wraps modulo the depth. The running sum is 8+DEPTH_LOG2 bits wide.
  - On each accepted sample: sum ← sum + new − overwritten entry.
  - This arithmetic never overflows and never underflows.
- Fill counter: counts accepted samples and saturates at 2^DEPTH_LOG2.
  - Filt_Valid stays 0 until the window is full.
  - From the sample that fills the window onward, every accepted sample produces one Filt_Valid pulse.
- Distance_Filt = sum >> DEPTH_LOG2, truncating. It holds its value between strobes.
- FSM codes: DISARMED=0, WATCH=1, PENDING=2, ALERT=3. The FSM is evaluated only in cycles where Filt_Valid=1, except for the Arm checks below. One counter, confirm count, is shared by PENDING and ALERT.
- DISARMED: Arm=1 → WATCH.
- WATCH: near sample → PENDING with count=1. If CONFIRM=1, go directly to ALERT instead.
- PENDING: near sample → count+1; when count reaches CONFIRM → ALERT with count=0. Non-near sample → WATCH, count=0.
- ALERT: clear sample → count+1; when count reaches CONFIRM → WATCH with count=0. Sample below CLEAR_CM → count=0 and stay in ALERT (hysteresis band).
- Arm=0 in any state → DISARMED on the next edge with count=0. This has priority over a simultaneous Filt_Valid.
- The window and averaging run regardless of Arm.
- Intrusion is a register set on the edge that enters ALERT and cleared on the edge that leaves it.

## Timing
- Reset values:
  - Distance_Filt=0, Filt_Valid=0, Intrusion=0, State=0 (DISARMED).
  - Sum, window entries, pointer, fill count and confirm count all 0.
  - Asserting RST clears everything immediately, including mid-operation. After release, a full window of new samples is required before Filt_Valid pulses again.
- Sample_Valid sampled high at edge t:
  - Distance_Filt and Filt_Valid are valid after edge t+1.
  - State and Intrusion update at edge t+2.
- Arm falling at edge t: State=0 and Intrusion=0 after edge t+1.
- Sample_Valid must not be ignored. Sustained 1-per-cycle input rate is supported.

## Test plan
- Reset, Arm=0, feed 100,100,100,100 → Filt_Valid is 0 for the first three samples and pulses on the fourth with Distance_Filt=100; State stays 0. Then feed 10,11,11,11 → final Distance_Filt=10 (43>>2, truncation).
- Feed 0,0,0,0 → Distance_Filt=255 (zero substituted).
- Arm=1, feed 20 ×6 → filtered outputs 4, 5 and 6 are near, so State goes 2, 2, 3. Intrusion=1 two cycles after the sixth Sample_Valid.
- From ALERT with the window all 20, feed 45 ×6 → Distance_Filt=26, 32, 38, 45, 45, 45. The first three outputs are below CLEAR_CM and reset the confirm count. The last three are clear → WATCH, Intrusion=0 two cycles after the sixth sample. A stream of 35s in ALERT keeps Intrusion=1 indefinitely.
- In PENDING with count=2, drop Arm in the same cycle as a near Filt_Valid → State=0 next cycle and Intrusion never asserts.
- Assert RST for one cycle while in ALERT → all outputs 0 immediately. After release, feed 20 ×3 → no Filt_Valid pulse.
